bram_rd_arbiter: RTL and testbench

- Shares the single read port of the block-memory transition table (4096-bit word, 17-bit address) between several CSR_traversal engines.
- Round-robin arbitration with at most one outstanding read per requester.
- Drives the memory address and enable, tracks in-flight reads through the fixed memory read latency, and returns a per-requester response strobe.
- Sits between the CSR_traversal instances and the design_1_wrapper memory port.

---
 rtl/bram_rd_arbiter_pkg.sv | 22 ++
 rtl/bram_rd_arbiter_rr_arbiter.sv | 39 +++
 rtl/bram_rd_arbiter.sv | 103 ++++++++++
 tb/tb_bram_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_arbiter_pkg.sv
// Shared definitions for the transition-table read arbiter.
package blk_mem_arb_pkg;

    // Memory geometry of the transition table.
    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned DEF_DATA_W = 4096;

    // Widest requester id the tag type can carry (up to 8 requesters).
    localparam int unsigned MAX_ID_W = 3;

    // Width of requester id / priority pointer, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One in-flight read: valid flag plus the id of the requester that owns it.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bram_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after pointer.
module rr_arbiter
    import blk_mem_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] pointer,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic            found;
    logic [ID_W:0]   scan_ext;
    logic [ID_W-1:0] scan_idx;

    // Walk pointer, pointer+1, ... with wrap by compare so N need not be 2**k.
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        found    = 1'b0;
        scan_ext = '0;
        scan_idx = '0;
        for (int unsigned j = 0; j < N; j++) begin
            scan_ext = {1'b0, pointer} + (ID_W + 1)'(j);
            if (scan_ext >= (ID_W + 1)'(N)) begin
                scan_ext = scan_ext - (ID_W + 1)'(N);
            end
            scan_idx = scan_ext[ID_W-1:0];
            if (!found && eligible[scan_idx]) begin
                found         = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_id        = scan_idx;
            end
        end
    end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares the transition-table read port between several traversal engines.
// One outstanding read per requester, round-robin priority, fixed-latency
// response routed back by a tag pipeline that shadows the memory pipeline.
module bram_rd_arbiter
    import blk_mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic                    bram_en,
    input  logic [DATA_W-1:0]       bram_dout
);

    localparam int unsigned ID_W = clog2_min1(N_REQ);

    logic [N_REQ-1:0]  outstanding;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic [ID_W-1:0]   pointer;
    logic [ID_W-1:0]   bram_id;
    logic [ADDR_W-1:0] sel_addr;
    tag_t              tag_pipe [RD_LAT];
    tag_t              tag_out;

    assign eligible = req & ~outstanding;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .eligible (eligible),
        .pointer  (pointer),
        .gnt      (arb_gnt),
        .gnt_id   (arb_id)
    );

    // Grant is suppressed while reset is held.
    always_comb begin
        gnt = reset ? '0 : arb_gnt;
    end

    // Address of the requester currently being granted.
    always_comb begin
        sel_addr = req_addr[32'(arb_id) * ADDR_W +: ADDR_W];
    end

    // Oldest tag is aligned with the memory output; decode it to a one-hot strobe.
    assign tag_out = tag_pipe[RD_LAT-1];

    always_comb begin
        rvalid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rvalid[i] = tag_out.valid && !reset && (tag_out.id == MAX_ID_W'(i));
        end
    end

    assign rdata = bram_dout;

    // Memory request register, outstanding mask and priority pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            bram_en     <= 1'b0;
            bram_addr   <= '0;
            bram_id     <= '0;
            pointer     <= '0;
            outstanding <= '0;
        end else begin
            bram_en     <= |gnt;
            outstanding <= (outstanding & ~rvalid) | gnt;
            if (|gnt) begin
                bram_addr <= sel_addr;
                bram_id   <= arb_id;
                pointer   <= (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
            end
        end
    end

    // Tag pipeline fed from the registered enable so it lines up with bram_dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: bram_en, id: MAX_ID_W'(bram_id)};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Bench for bram_rd_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_bram_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 64;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   bram_addr;
    logic            bram_en;
    logic [DW-1:0]   bram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    bram_rd_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 15'h1234, a ^ 17'h1ABCD, 15'h07A5};
    endfunction

    // Memory with RL cycles of read latency after the registered address.
    logic [AW-1:0] mpipe [RL];
    always @(posedge clk) begin
        mpipe[0] <= bram_addr;
        for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bram_dout = mem_word(mpipe[RL-1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        int            due;
    } fl_t;

    fl_t           fl[$];
    bit            outst [N];
    int            ptr;
    bit            exp_en;
    logic [AW-1:0] exp_addr;
    bit            model_live = 0;
    int            cyc = 0;

    always @(negedge clk) begin
        logic [N-1:0]  eg;
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        int            k;
        int            kk;
        bit            found;
        eg = '0; ev = '0; ed = '0; kk = 0; found = 0;
        if (model_live) begin
            if (!reset) begin
                for (int j = 0; j < N; j++) begin
                    k = (ptr + j) % N;
                    if (!found && req[k] && !outst[k]) begin
                        found = 1; kk = k; eg[k] = 1'b1;
                    end
                end
                if (fl.size() > 0 && fl[0].due == cyc) begin
                    ev[fl[0].id] = 1'b1;
                    ed = mem_word(fl[0].addr);
                end
            end
            check("m_gnt", 64'(gnt), 64'(eg));
            check("m_rvalid", 64'(rvalid), 64'(ev));
            check("m_bram_en", 64'(bram_en), 64'(exp_en));
            check("m_bram_addr", 64'(bram_addr), 64'(exp_addr));
            if (ev != '0) check("m_rdata", 64'(rdata), 64'(ed));
        end
        if (reset) begin
            fl.delete();
            for (int i = 0; i < N; i++) outst[i] = 0;
            ptr = 0; exp_en = 0; exp_addr = '0;
            model_live = 1;
        end else if (model_live) begin
            if (ev != '0) begin
                outst[fl[0].id] = 0;
                void'(fl.pop_front());
            end
            if (found) begin
                fl.push_back('{id: kk, addr: req_addr[kk*AW +: AW], due: cyc + 1 + RL});
                outst[kk] = 1;
                ptr       = (kk + 1) % N;
                exp_en    = 1;
                exp_addr  = req_addr[kk*AW +: AW];
            end else begin
                exp_en = 0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with reset low.
    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        logic [N-1:0]  r;
        logic [N-1:0]  g;
        logic [N-1:0]  e;
        logic [N-1:0]  prev;
        logic [AW-1:0] held;

        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(17'h100 * (i + 1) + 3));
        tick();

        // All four requesting from reset; each drops req once granted.
        do_reset();
        r = 4'b1111;
        for (int c = 0; c <= 6; c++) begin
            req = r;
            @(negedge clk);
            g = gnt;
            e = (c < 4) ? N'(1 << c) : '0;
            check("all4_gnt", 64'(gnt), 64'(e));
            e = (c >= 3) ? N'(1 << (c - 3)) : '0;
            check("all4_rvalid", 64'(rvalid), 64'(e));
            check("all4_en", 64'(bram_en), 64'((c >= 1 && c <= 4) ? 1 : 0));
            r = r & ~g;
            tick();
        end

        // Single request from requester 1, then idle.
        do_reset();
        set_addr(1, 17'h00A5);
        for (int c = 0; c <= 13; c++) begin
            req = (c == 10) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (c == 10) check("single_gnt", 64'(gnt), 64'(4'b0010));
            if (c == 11) begin
                check("single_en", 64'(bram_en), 64'(1));
                check("single_addr", 64'(bram_addr), 64'(17'h00A5));
            end
            if (c == 13) begin
                check("single_rvalid", 64'(rvalid), 64'(4'b0010));
                check("single_rdata", 64'(rdata), 64'(mem_word(17'h00A5)));
            end
            tick();
        end
        held = bram_addr;
        req  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_gnt", 64'(gnt), 64'(0));
            check("idle_en", 64'(bram_en), 64'(0));
            check("idle_addr", 64'(bram_addr), 64'(held));
            check("idle_rvalid", 64'(rvalid), 64'(0));
            tick();
        end

        // Rotation fairness with req0 and req2 held.
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = (c % 4 == 0) ? 4'b0001 : (c % 4 == 1) ? 4'b0100 : 4'b0000;
            check("rot_gnt", 64'(gnt), 64'(e));
            tick();
        end

        // Outstanding block: req3 held, re-granted only every RL+2 cycles.
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            e = (c % 4 == 0) ? 4'b1000 : 4'b0000;
            check("blk_gnt", 64'(gnt), 64'(e));
            tick();
        end

        // Reset while a read is in flight.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            req   = (c == 5) ? 4'b0010 : (c >= 8) ? 4'b1111 : 4'b0000;
            reset = (c == 6);
            @(negedge clk);
            if (c == 5) check("rst_gnt1", 64'(gnt), 64'(4'b0010));
            if (c >= 6) check("rst_rvalid", 64'(rvalid), 64'(0));
            if (c == 6) check("rst_en6", 64'(bram_en), 64'(1));
            if (c == 7) check("rst_en7", 64'(bram_en), 64'(0));
            if (c == 8) check("rst_gnt_after", 64'(gnt), 64'(4'b0001));
            tick();
        end
        reset = 1'b0;

        // Random traffic: requesters hold until granted, occasional resets.
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = gnt;
            tick();
            prev = req;
            r    = req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (g[i]) r[i] = ($urandom_range(0, 1) == 1);
                end else begin
                    r[i] = ($urandom_range(0, 2) == 0);
                end
                if (r[i] && (g[i] || !prev[i])) set_addr(i, AW'($urandom));
            end
            reset = ($urandom_range(0, 99) == 0);
            req   = r;
        end
        reset = 1'b0;
        req   = '0;
        repeat (RL + 3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
